// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone classic-cycle initiator.
package wb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  localparam int unsigned DEF_TIMEOUT = 255;
  localparam int unsigned DEF_ERRW    = 8;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

endpackage

// File: rtl/wb_master_port_timeout.sv
// Clearable, non-wrapping cycle counter; o_tc flags the last allowed strobe cycle.
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  // TIMEOUT=0 still needs a legal (1-bit) counter even though o_tc never fires.
  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIM = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (TIMEOUT != 0) && (r_cnt == LIM);

endmodule

// File: rtl/wb_master_port.sv
// Single-outstanding Wishbone classic initiator: valid/ready command in,
// registered bus cycle with ack timeout, valid/ready response out.
module wb_master_port
  import wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned ERRW    = DEF_ERRW
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [DAT_W-1:0] cmd_dat_i,
  input  logic [SEL_W-1:0] cmd_sel_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DAT_W-1:0] rsp_dat_o,
  output logic             rsp_err_o,
  output logic [ERRW-1:0]  err_cnt_o,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic [DAT_W-1:0] wb_dat_o,
  input  logic [DAT_W-1:0] wb_dat_i,
  output logic             wb_we_o,
  output logic [SEL_W-1:0] wb_sel_o,
  output logic             wb_stb_o,
  output logic             wb_cyc_o,
  input  logic             wb_ack_i
);

  state_t r_state, w_next;

  logic             w_accept, w_ack, w_tmo, w_tc;
  logic [ADR_W-1:0] r_adr;
  logic [DAT_W-1:0] r_dat;
  logic             r_we;
  logic [SEL_W-1:0] r_sel;
  logic             r_cyc;
  logic [DAT_W-1:0] r_rsp_dat;
  logic             r_rsp_err;
  logic [ERRW-1:0]  r_err_cnt;

  wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .i_clk (wb_clk_i),
    .i_rst (wb_rst_i),
    .i_clr (w_accept),
    .i_en  (r_state == ST_BUS),
    .o_tc  (w_tc)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Ack has priority over the timeout terminal count in the same cycle.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_ack    = 1'b0;
    w_tmo    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          w_accept = 1'b1;
          w_next   = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wb_ack_i) begin
          w_ack  = 1'b1;
          w_next = ST_RSP;
        end else if (w_tc) begin
          w_tmo  = 1'b1;
          w_next = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready_i) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_adr     <= '0;
      r_dat     <= '0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_cyc     <= 1'b0;
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_adr <= cmd_adr_i;
        r_dat <= cmd_dat_i;
        r_we  <= cmd_we_i;
        r_sel <= cmd_sel_i;
        r_cyc <= 1'b1;
      end
      if (w_ack) begin
        r_cyc     <= 1'b0;
        r_rsp_dat <= r_we ? '0 : wb_dat_i;
        r_rsp_err <= 1'b0;
      end
      if (w_tmo) begin
        r_cyc     <= 1'b0;
        r_rsp_dat <= '0;
        r_rsp_err <= 1'b1;
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign cmd_ready_o = (r_state == ST_IDLE);
  assign rsp_valid_o = (r_state == ST_RSP);
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;
  assign err_cnt_o   = r_err_cnt;
  assign wb_adr_o    = r_adr;
  assign wb_dat_o    = r_dat;
  assign wb_we_o     = r_we;
  assign wb_sel_o    = r_sel;
  assign wb_cyc_o    = r_cyc;
  assign wb_stb_o    = r_cyc;

endmodule

// File: tb/tb_wb_master_port.sv
// Self-checking bench for wb_master_port with TIMEOUT=4, ERRW=2.
module tb_wb_master_port;

  localparam int TMO  = 4;
  localparam int EW   = 2;
  localparam int EMAX = (1 << EW) - 1;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic [EW-1:0] err_cnt;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic        wb_we, wb_stb, wb_cyc, wb_ack;
  logic [3:0]  wb_sel;

  int n_chk = 0;
  int n_err = 0;
  int ecnt  = 0;

  wb_master_port #(.TIMEOUT(TMO), .ERRW(EW)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .err_cnt_o   (err_cnt),
    .wb_adr_o    (wb_adr),
    .wb_dat_o    (wb_dat_o),
    .wb_dat_i    (wb_dat_i),
    .wb_we_o     (wb_we),
    .wb_sel_o    (wb_sel),
    .wb_stb_o    (wb_stb),
    .wb_cyc_o    (wb_cyc),
    .wb_ack_i    (wb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_dly;  // stb cycle in which the slave acks; 0 = never
    int          rsp_dly;  // cycles rsp_ready stays low in RSP
    logic [31:0] sdat;
    int          exp_stb;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int ack_dly, input int rsp_dly,
                         input logic [31:0] sdat, input int exp_stb, input logic exp_err,
                         input logic [31:0] exp_dat);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom); cmd_we = 1'($urandom);
    n = 0;
    while (wb_stb === 1'b1 && n < 50) begin
      n++;
      chk("bus_adr", wb_adr, adr);
      chk("bus_dat", wb_dat_o, dat);
      chk("bus_we", {31'd0, wb_we}, {31'd0, we});
      chk("bus_sel", {28'd0, wb_sel}, {28'd0, sel});
      chk("bus_cyc", {31'd0, wb_cyc}, 32'd1);
      chk("cmd_ready_bus", {31'd0, cmd_ready}, 32'd0);
      wb_ack   = (n == ack_dly);
      wb_dat_i = (n == ack_dly) ? sdat : $urandom;
      @(negedge clk);
    end
    wb_ack = 1'b0;
    chk("stb_cycles", n, exp_stb);
    chk("cyc_low", {31'd0, wb_cyc}, 32'd0);
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    chk("rsp_dat", rsp_dat, exp_dat);
    for (int i = 0; i < rsp_dly; i++) begin
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_dat", rsp_dat, exp_dat);
      chk("hold_err", {31'd0, rsp_err}, {31'd0, exp_err});
      chk("hold_ready", {31'd0, cmd_ready}, 32'd0);
      wb_ack   = (i == 1);
      wb_dat_i = $urandom;
      @(negedge clk);
    end
    wb_ack = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", {31'd0, rsp_valid}, 32'd0);
    chk("ready_after", {31'd0, cmd_ready}, 32'd1);
    if (exp_err && ecnt < EMAX) ecnt++;
    chk("err_cnt", {30'd0, err_cnt}, ecnt);
  endtask

  vec_t vecs[6];

  initial begin
    int ack, rdly, est;
    logic we, eerr;
    logic [31:0] adr, dat, sd, edat;
    logic [3:0] sel;

    vecs[0] = '{1'b0, 32'h0010_0000, 32'h0, 4'hF, 2, 0, 32'h0000_0060, 2, 1'b0, 32'h0000_0060};
    vecs[1] = '{1'b1, 32'h0020_0000, 32'h41, 4'h1, 1, 0, 32'hDEAD_BEEF, 1, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h0030_0004, 32'h0, 4'hF, 0, 1, 32'h1111_2222, 4, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h0030_0008, 32'h0, 4'hF, 4, 0, 32'h1234_5678, 4, 1'b0, 32'h1234_5678};
    vecs[4] = '{1'b0, 32'h0040_0000, 32'h0, 4'h3, 3, 5, 32'hA5A5_0001, 3, 1'b0, 32'hA5A5_0001};
    vecs[5] = '{1'b1, 32'h0050_0010, 32'hCAFE, 4'hC, 0, 2, 32'h7777_7777, 4, 1'b1, 32'h0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wb_dat_i = '0; wb_ack = 1'b0;
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_err_cnt", {30'd0, err_cnt}, 32'd0);
    chk("rst_wb_adr", wb_adr, 32'd0);
    chk("rst_wb_dat", wb_dat_o, 32'd0);
    chk("rst_wb_ctl", {26'd0, wb_we, wb_sel, wb_stb}, 32'd0);
    chk("rst_wb_cyc", {31'd0, wb_cyc}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      run_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].ack_dly,
              vecs[i].rsp_dly, vecs[i].sdat, vecs[i].exp_stb, vecs[i].exp_err, vecs[i].exp_dat);

    // Back-to-back writes with rsp_ready held high: next handshake 3 edges later.
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h0020_0000; cmd_dat = 32'h41; cmd_sel = 4'h1;
    chk("b2b_ready0", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    chk("b2b_stb", {31'd0, wb_stb}, 32'd1);
    chk("b2b_dat", wb_dat_o, 32'h41);
    chk("b2b_sel", {28'd0, wb_sel}, 32'h1);
    chk("b2b_ready1", {31'd0, cmd_ready}, 32'd0);
    wb_ack = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
    cmd_adr = 32'h0020_0004; cmd_dat = 32'h42;
    @(negedge clk);
    wb_ack = 1'b0;
    chk("b2b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_rsp_dat", rsp_dat, 32'd0);
    chk("b2b_ready2", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_ready3", {31'd0, cmd_ready}, 32'd1);
    chk("b2b_rsp_gone", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_second_stb", {31'd0, wb_stb}, 32'd1);
    chk("b2b_second_adr", wb_adr, 32'h0020_0004);
    chk("b2b_second_dat", wb_dat_o, 32'h42);
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    chk("b2b_second_rsp", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b_idle", {31'd0, cmd_ready}, 32'd1);

    // Randomized transactions against the transaction-level model.
    for (int t = 0; t < 40; t++) begin
      we   = 1'($urandom);
      adr  = $urandom;
      dat  = $urandom;
      sel  = 4'($urandom);
      sd   = $urandom;
      ack  = $urandom_range(0, 6);
      rdly = $urandom_range(0, 3);
      eerr = (ack == 0) || (ack > TMO);
      est  = eerr ? TMO : ack;
      edat = (eerr || we) ? 32'd0 : sd;
      run_txn(we, adr, dat, sel, ack, rdly, sd, est, eerr, edat);
    end

    // Reset in the 2nd strobe cycle drops the transaction.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0060_0000; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_stb1", {31'd0, wb_stb}, 32'd1);
    @(negedge clk);
    chk("mid_stb2", {31'd0, wb_stb}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_stb", {31'd0, wb_stb}, 32'd0);
    chk("mid_rst_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mid_rst_errcnt", {30'd0, err_cnt}, 32'd0);
    ecnt = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_ack = (i == 1);
      @(negedge clk);
      chk("post_rst_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("post_rst_stb", {31'd0, wb_stb}, 32'd0);
      chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    end
    wb_ack = 1'b0;

    // Error counter saturates at 3 with a 2-bit counter.
    for (int i = 0; i < 5; i++)
      run_txn(1'b0, 32'h0070_0000 + i, 32'h0, 4'hF, 0, 0, 32'h0, TMO, 1'b1, 32'h0);
    chk("err_cnt_sat", {30'd0, err_cnt}, 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
